// File: rtl/la_capture_seq.sv
// rtl/la_capture_seq.sv - logic analyser capture sequencer: arm delay, trigger, capture to memory, upload handshake
module la_capture_seq #(
    parameter int AW   = 10,
    parameter int BASE = 29,
    parameter int LAST = 767
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    input  logic [7:0]    cfg_mode,
    input  logic [7:0]    cfg_delay,
    input  logic [7:0]    cfg_mask,
    input  logic [7:0]    cfg_pol,
    input  logic          tick,
    input  logic          smp_en,
    input  logic [7:0]    din,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic [7:0]    trig_prev,
    output logic [7:0]    trig_cur,
    output logic          up_req,
    input  logic          up_ack,
    output logic [7:0]    frame_cnt,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DELAY     = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_CAPTURE   = 3'd3,
        S_UPLOAD    = 3'd4
    } state_t;

    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [AW-1:0] LAST_A = AW'(LAST);

    state_t        st;
    logic          run_en;
    logic          edge_mode;
    logic [7:0]    delay_q;
    logic [7:0]    mask_q;
    logic [7:0]    pol_q;
    logic [7:0]    prev;
    logic [7:0]    dly_cnt;
    logic          hit;
    logic [AW-1:0] next_addr;

    // prev is the sample before this strobe; it only updates on the clock edge
    always_comb begin
        hit       = !edge_mode || (((din ^ prev) & mask_q & (din ^ pol_q)) != 8'd0);
        next_addr = mem_addr + 1'b1;
    end

    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            run_en    <= 1'b0;
            edge_mode <= 1'b0;
            delay_q   <= 8'd0;
            mask_q    <= 8'd0;
            pol_q     <= 8'd0;
            prev      <= 8'd0;
            dly_cnt   <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            trig_prev <= 8'd0;
            trig_cur  <= 8'd0;
            up_req    <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            if (smp_en) begin
                prev <= din;
            end
            if (cfg_valid) begin
                run_en    <= cfg_mode[5];
                edge_mode <= cfg_mode[6];
                delay_q   <= cfg_delay;
                mask_q    <= cfg_mask;
                pol_q     <= cfg_pol;
            end
            case (st)
                S_IDLE: begin
                    if (!cfg_valid && run_en) begin
                        st      <= S_DELAY;
                        dly_cnt <= 8'd0;
                    end
                end
                S_DELAY: begin
                    if (cfg_valid) begin
                        st <= S_IDLE;
                    end else if (delay_q < 8'd2) begin
                        st <= S_WAIT_TRIG;
                    end else if (tick) begin
                        dly_cnt <= dly_cnt + 8'd1;
                        if (dly_cnt + 8'd1 == delay_q) begin
                            st <= S_WAIT_TRIG;
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (cfg_valid) begin
                        st <= S_IDLE;
                    end else if (smp_en && hit) begin
                        trig_prev <= prev;
                        trig_cur  <= din;
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_A;
                        mem_wdata <= din;
                        up_req    <= (BASE_A == LAST_A);
                        st        <= (BASE_A == LAST_A) ? S_UPLOAD : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cfg_valid) begin
                        st <= S_IDLE;
                    end else if (smp_en) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= next_addr;
                        mem_wdata <= din;
                        if (next_addr == LAST_A) begin
                            up_req <= 1'b1;
                            st     <= S_UPLOAD;
                        end
                    end
                end
                S_UPLOAD: begin
                    // a config written during upload is already latched and decides the next state here
                    if (up_ack) begin
                        up_req    <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                        dly_cnt   <= 8'd0;
                        st        <= run_en ? S_DELAY : S_IDLE;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_la_capture_seq.sv
// tb/tb_la_capture_seq.sv - directed and randomized bench for la_capture_seq
module tb_la_capture_seq;

    localparam int AW     = 10;
    localparam int BASE   = 29;
    localparam int LAST   = 767;
    localparam int LAST_S = 32;
    localparam int NCAP   = LAST - BASE + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cfg_valid, tick, smp_en, up_ack;
    logic [7:0]    cfg_mode, cfg_delay, cfg_mask, cfg_pol, din;
    logic          mem_we, up_req, mem_we_s, up_req_s;
    logic [AW-1:0] mem_addr, mem_addr_s;
    logic [7:0]    mem_wdata, trig_prev, trig_cur, frame_cnt;
    logic [7:0]    mem_wdata_s, trig_prev_s, trig_cur_s, frame_cnt_s;
    logic [2:0]    state, state_s;

    int checks = 0;
    int errors = 0;

    la_capture_seq #(.AW(AW), .BASE(BASE), .LAST(LAST)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
        .cfg_delay(cfg_delay), .cfg_mask(cfg_mask), .cfg_pol(cfg_pol),
        .tick(tick), .smp_en(smp_en), .din(din),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .trig_prev(trig_prev), .trig_cur(trig_cur), .up_req(up_req),
        .up_ack(up_ack), .frame_cnt(frame_cnt), .state(state)
    );

    la_capture_seq #(.AW(AW), .BASE(BASE), .LAST(LAST_S)) dut_s (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
        .cfg_delay(cfg_delay), .cfg_mask(cfg_mask), .cfg_pol(cfg_pol),
        .tick(tick), .smp_en(smp_en), .din(din),
        .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
        .trig_prev(trig_prev_s), .trig_cur(trig_cur_s), .up_req(up_req_s),
        .up_ack(up_ack), .frame_cnt(frame_cnt_s), .state(state_s)
    );

    typedef struct {
        int         addr;
        logic [7:0] data;
        logic       upr;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] exp_d[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back('{addr: int'(mem_addr), data: mem_wdata, upr: up_req});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] m, input logic [7:0] d, input logic [7:0] k, input logic [7:0] p);
        cfg_mode  = m;
        cfg_delay = d;
        cfg_mask  = k;
        cfg_pol   = p;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic smp(input logic [7:0] v);
        din    = v;
        smp_en = 1'b1;
        step();
        smp_en = 1'b0;
    endtask

    // writes must be exactly the expected samples at BASE, BASE+1, ... in order
    function automatic int wr_bad();
        int b = 0;
        if (wq.size() != exp_d.size()) b++;
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i >= wq.size()) b++;
            else if (wq[i].addr != BASE + i || wq[i].data !== exp_d[i]) b++;
        end
        return b;
    endfunction

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_we"}, mem_we, 0);
        chk({pfx, "_addr"}, mem_addr, 0);
        chk({pfx, "_wdata"}, mem_wdata, 0);
        chk({pfx, "_tprev"}, trig_prev, 0);
        chk({pfx, "_tcur"}, trig_cur, 0);
        chk({pfx, "_upreq"}, up_req, 0);
        chk({pfx, "_frame"}, frame_cnt, 0);
        chk({pfx, "_state"}, state, 0);
    endtask

    initial begin
        logic [7:0] v, p, mask, pol, mprev, e_tp, e_tc;
        int         dly, bad, ncap;
        bit         trig;

        rst = 1'b1; cfg_valid = 1'b0; tick = 1'b0; smp_en = 1'b0; up_ack = 1'b0;
        cfg_mode = 8'd0; cfg_delay = 8'd0; cfg_mask = 8'd0; cfg_pol = 8'd0; din = 8'd0;
        step(); step();
        chk_all_zero("rst");
        rst = 1'b0;
        step();

        // immediate mode, full capture BASE..LAST, upload handshake
        cfg(8'h20, 8'd0, 8'd0, 8'd0);
        chk("a_cfg_idle", state, 0);
        step(); chk("a_delay", state, 1);
        step(); chk("a_wait", state, 2);
        wq.delete(); exp_d.delete();
        for (int k = 0; k < NCAP; k++) begin
            v = 8'($urandom);
            exp_d.push_back(v);
            smp(v);
            if (k == 0) begin
                chk("a_first_we", mem_we, 1);
                chk("a_first_state", state, 3);
            end
            step();
            if (k == 0) chk("a_we_one_cycle", mem_we, 0);
            step(); step();
        end
        chk("a_nwrites", wq.size(), NCAP);
        chk("a_data", wr_bad(), 0);
        chk("a_upr_last", (wq.size() == NCAP) ? wq[NCAP-1].upr : 1'b0, 1);
        chk("a_upr_prev", (wq.size() == NCAP) ? wq[NCAP-2].upr : 1'b1, 0);
        chk("a_upreq", up_req, 1);
        chk("a_upload", state, 4);
        smp(8'($urandom)); step();
        chk("a_upload_nowrite", wq.size(), NCAP);
        up_ack = 1'b1; step(); up_ack = 1'b0;
        chk("a_ack_upreq", up_req, 0);
        chk("a_frame1", frame_cnt, 1);
        chk("a_ack_delay", state, 1);
        step(); chk("a_rearm", state, 2);
        cfg(8'h00, 8'd0, 8'd0, 8'd0);
        chk("a_abort", state, 0);

        // delay of 5 ticks, samples during DELAY are not written
        wq.delete();
        smp(8'h5A);
        cfg(8'h20, 8'd5, 8'd0, 8'd0);
        chk("b_cfg_idle", state, 0);
        step(); chk("b_delay", state, 1);
        for (int t = 1; t <= 5; t++) begin
            step();
            tick = 1'b1; din = 8'($urandom); smp_en = 1'b1;
            step();
            tick = 1'b0; smp_en = 1'b0;
            chk($sformatf("b_tick%0d", t), state, (t == 5) ? 3'd2 : 3'd1);
        end
        cfg(8'h00, 8'd0, 8'd0, 8'd0);
        chk("b_no_write", wq.size(), 0);
        chk("b_abort", state, 0);

        // edge-mask polarity, then abort after the BASE+100 write
        wq.delete(); exp_d.delete();
        smp(8'h00);
        cfg(8'h60, 8'd0, 8'h01, 8'h01);
        step(); step();
        chk("c_wait", state, 2);
        smp(8'h01);
        chk("c_pol_block", state, 2);
        smp(8'h00);
        chk("c_trig_state", state, 3);
        chk("c_trig_prev", trig_prev, 8'h01);
        chk("c_trig_cur", trig_cur, 8'h00);
        chk("c_trig_addr", mem_addr, BASE);
        exp_d.push_back(8'h00);
        for (int k = 1; k <= 100; k++) begin
            v = 8'($urandom);
            exp_d.push_back(v);
            smp(v);
        end
        chk("c_addr100", mem_addr, BASE + 100);
        cfg_mode = 8'h00; cfg_valid = 1'b1; smp_en = 1'b1; din = 8'hA5;
        step();
        cfg_valid = 1'b0; smp_en = 1'b0;
        chk("c_abort_state", state, 0);
        for (int k = 0; k < 3; k++) smp(8'($urandom));
        step();
        chk("c_nwrites", wq.size(), 101);
        chk("c_data", wr_bad(), 0);

        // randomized edge-mask capture against the trigger rule
        wq.delete(); exp_d.delete();
        p = 8'($urandom);
        smp(p);
        mask = 8'($urandom_range(1, 255));
        pol  = 8'($urandom);
        dly  = $urandom_range(2, 6);
        cfg(8'h60, 8'(dly), mask, pol);
        step(); chk("d_delay", state, 1);
        for (int t = 1; t <= dly; t++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        chk("d_wait", state, 2);
        mprev = p; trig = 1'b0; ncap = 0; e_tp = 8'd0; e_tc = 8'd0;
        for (int n = 0; n < 4000 && ncap < NCAP; n++) begin
            v = 8'($urandom);
            repeat ($urandom_range(0, 2)) step();
            if (!trig && ((v ^ mprev) & mask & (v ^ pol)) != 8'd0) begin
                trig = 1'b1; e_tp = mprev; e_tc = v;
            end
            if (trig) begin
                exp_d.push_back(v);
                ncap++;
            end
            mprev = v;
            smp(v);
        end
        step(); step();
        chk("d_nwrites", wq.size(), NCAP);
        chk("d_data", wr_bad(), 0);
        chk("d_trig_prev", trig_prev, e_tp);
        chk("d_trig_cur", trig_cur, e_tc);
        chk("d_upreq", up_req, 1);
        cfg(8'h00, 8'd0, 8'd0, 8'd0);
        chk("d_cfg_in_upload", state, 4);
        up_ack = 1'b1; step(); up_ack = 1'b0;
        chk("d_ack_idle", state, 0);
        chk("d_frame2", frame_cnt, 2);
        up_ack = 1'b1; step(); up_ack = 1'b0;
        chk("d_ack_ignored", frame_cnt, 2);

        // asynchronous reset in the middle of a capture
        cfg(8'h20, 8'd0, 8'd0, 8'd0);
        step(); step();
        smp(8'($urandom)); smp(8'($urandom));
        chk("e_capture", state, 3);
        chk("e_we_high", mem_we, 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("e_async");
        step(); rst = 1'b0;
        step(); step(); step();
        chk("e_stay_idle", state, 0);
        cfg(8'h20, 8'd0, 8'd0, 8'd0);
        step();
        chk("e_resume", state, 1);

        // 256 short uploads on the small instance wrap frame_cnt
        rst = 1'b1; step(); rst = 1'b0;
        cfg(8'h20, 8'd0, 8'd0, 8'd0);
        step(); step();
        chk("f_wait", state_s, 2);
        bad = 0;
        for (int i = 1; i <= 256; i++) begin
            repeat (4) smp(8'($urandom));
            if (up_req_s !== 1'b1 || state_s !== 3'd4) bad++;
            up_ack = 1'b1; step(); up_ack = 1'b0;
            if (frame_cnt_s !== 8'(i) || up_req_s !== 1'b0) bad++;
            if (i == 255) chk("f_cnt255", frame_cnt_s, 255);
            step();
            if (state_s !== 3'd2) bad++;
        end
        chk("f_cycle_bad", bad, 0);
        chk("f_wrap", frame_cnt_s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
